pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl_pkg.sv | 27 ++
 rtl/pipe_stall_ctrl_if.sv | 51 +++++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned WAIT_CNT_W  = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // SRAM access sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when a producer writing dest feeds one of the consumer's sources; r0 never matches
    function automatic logic reg_match(
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src1,
        input logic [REG_W-1:0] src2,
        input logic             two_src
    );
        return (dest != REG_ZERO) && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side signal bundle between the stage datapath and the stall sequencer.
interface pipe_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);

    logic [REG_W-1:0] ID_src1;
    logic [REG_W-1:0] ID_src2;
    logic             ID_two_src;
    logic [REG_W-1:0] EXE_dest;
    logic             EXE_MEM_R_en;
    logic             EXE_WB_en;
    logic [REG_W-1:0] MEM_dest;
    logic             MEM_R_en;
    logic             MEM_W_en;
    logic             MEM_WB_en;
    logic             branch_taken;
    logic             sram_ready;

    logic             sram_req;
    logic             IF_en;
    logic             ID_en;
    logic             EXE_en;
    logic             MEM_en;
    logic             IF_flush;
    logic             ID_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    // Datapath / SRAM side
    modport master (
        output ID_src1, ID_src2, ID_two_src,
        output EXE_dest, EXE_MEM_R_en, EXE_WB_en,
        output MEM_dest, MEM_R_en, MEM_W_en, MEM_WB_en,
        output branch_taken, sram_ready,
        input  sram_req, IF_en, ID_en, EXE_en, MEM_en,
        input  IF_flush, ID_bubble, mem_err, stall_cycles
    );

    // Stall controller side
    modport slave (
        input  ID_src1, ID_src2, ID_two_src,
        input  EXE_dest, EXE_MEM_R_en, EXE_WB_en,
        input  MEM_dest, MEM_R_en, MEM_W_en, MEM_WB_en,
        input  branch_taken, sram_ready,
        output sram_req, IF_en, ID_en, EXE_en, MEM_en,
        output IF_flush, ID_bubble, mem_err, stall_cycles
    );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Data hazard detector: flags an ID instruction that must wait for an older result.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mem_r_en,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hz_c
);

    logic exe_hit_c;
    logic mem_hit_c;

    // With forwarding only a load in EXE stalls; without it any pending EXE/MEM writeback does
    always_comb begin
        exe_hit_c = reg_match(exe_dest, id_src1, id_src2, id_two_src);
        mem_hit_c = reg_match(mem_dest, id_src1, id_src2, id_two_src);
        hz_c      = exe_mem_r_en && exe_hit_c;
        if (!FWD_EN) begin
            hz_c = hz_c || (exe_wb_en && exe_hit_c) || (mem_wb_en && mem_hit_c);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, branch flush, SRAM wait freeze.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit          FWD_EN  = 1'b1,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_e                state_q,    state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q,  mem_err_d;
    logic [CNT_W-1:0]      stall_q,    stall_d;

    logic mem_access_c;
    logic mem_stall_c;
    logic hz_c;
    logic if_en_c;
    logic id_en_c;
    logic exe_en_c;
    logic mem_en_c;
    logic if_flush_c;
    logic id_bubble_c;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard (
        .id_src1      (bus.ID_src1),
        .id_src2      (bus.ID_src2),
        .id_two_src   (bus.ID_two_src),
        .exe_dest     (bus.EXE_dest),
        .exe_mem_r_en (bus.EXE_MEM_R_en),
        .exe_wb_en    (bus.EXE_WB_en),
        .mem_dest     (bus.MEM_dest),
        .mem_wb_en    (bus.MEM_WB_en),
        .hz_c         (hz_c)
    );

    assign mem_access_c = bus.MEM_R_en || bus.MEM_W_en;

    // State, wait counter, sticky error and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
        end
    end

    // SRAM access sequencing; DONE ignores mem_access since the MEM register still holds the finished access
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            IDLE: begin
                if (mem_access_c) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (bus.sram_ready) begin
                    state_d = DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = DONE;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage control muxing: memory freeze > branch flush > hazard stall > free-running
    always_comb begin
        mem_stall_c = ((state_q == IDLE) && mem_access_c) || (state_q == WAIT);
        if_en_c     = 1'b1;
        id_en_c     = 1'b1;
        exe_en_c    = 1'b1;
        mem_en_c    = 1'b1;
        if_flush_c  = 1'b0;
        id_bubble_c = 1'b0;
        if (mem_stall_c) begin
            if_en_c  = 1'b0;
            id_en_c  = 1'b0;
            exe_en_c = 1'b0;
            mem_en_c = 1'b0;
        end else if (bus.branch_taken) begin
            if_flush_c  = 1'b1;
            id_bubble_c = 1'b1;
        end else if (hz_c) begin
            if_en_c     = 1'b0;
            id_bubble_c = 1'b1;
        end
    end

    // Performance counter of frozen or hazard-stalled cycles, wrapping
    always_comb begin
        stall_d = stall_q;
        if (mem_stall_c || (hz_c && !bus.branch_taken)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign bus.sram_req     = mem_stall_c;
    assign bus.IF_en        = if_en_c;
    assign bus.ID_en        = id_en_c;
    assign bus.EXE_en       = exe_en_c;
    assign bus.MEM_en       = mem_en_c;
    assign bus.IF_flush     = if_flush_c;
    assign bus.ID_bubble    = id_bubble_c;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench: a forwarding controller (TIMEOUT=4) and a no-forwarding one share stimulus.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_mem_r_en, exe_wb_en;
    logic       mem_r_en, mem_w_en, mem_wb_en, branch_taken, sram_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(32)) bus0 ();
    pipe_stall_ctrl_if #(.CNT_W(32)) bus1 ();

    assign bus0.ID_src1      = id_src1;
    assign bus0.ID_src2      = id_src2;
    assign bus0.ID_two_src   = id_two_src;
    assign bus0.EXE_dest     = exe_dest;
    assign bus0.EXE_MEM_R_en = exe_mem_r_en;
    assign bus0.EXE_WB_en    = exe_wb_en;
    assign bus0.MEM_dest     = mem_dest;
    assign bus0.MEM_R_en     = mem_r_en;
    assign bus0.MEM_W_en     = mem_w_en;
    assign bus0.MEM_WB_en    = mem_wb_en;
    assign bus0.branch_taken = branch_taken;
    assign bus0.sram_ready   = sram_ready;

    assign bus1.ID_src1      = id_src1;
    assign bus1.ID_src2      = id_src2;
    assign bus1.ID_two_src   = id_two_src;
    assign bus1.EXE_dest     = exe_dest;
    assign bus1.EXE_MEM_R_en = exe_mem_r_en;
    assign bus1.EXE_WB_en    = exe_wb_en;
    assign bus1.MEM_dest     = mem_dest;
    assign bus1.MEM_R_en     = mem_r_en;
    assign bus1.MEM_W_en     = mem_w_en;
    assign bus1.MEM_WB_en    = mem_wb_en;
    assign bus1.branch_taken = branch_taken;
    assign bus1.sram_ready   = sram_ready;

    pipe_stall_ctrl #(.FWD_EN(1'b1), .TIMEOUT(4), .CNT_W(32)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    pipe_stall_ctrl #(.FWD_EN(1'b0), .TIMEOUT(4), .CNT_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // en = {IF,ID,EXE,MEM}, ctl = {sram_req, IF_flush, ID_bubble}
    task automatic chk0(input string tag, input logic [3:0] en, input logic [2:0] ctl);
        check_eq({tag, ".en"}, 32'({bus0.IF_en, bus0.ID_en, bus0.EXE_en, bus0.MEM_en}), 32'(en));
        check_eq({tag, ".ctl"}, 32'({bus0.sram_req, bus0.IF_flush, bus0.ID_bubble}), 32'(ctl));
    endtask

    task automatic chk1(input string tag, input logic [3:0] en, input logic [2:0] ctl);
        check_eq({tag, ".en1"}, 32'({bus1.IF_en, bus1.ID_en, bus1.EXE_en, bus1.MEM_en}), 32'(en));
        check_eq({tag, ".ctl1"}, 32'({bus1.sram_req, bus1.IF_flush, bus1.ID_bubble}), 32'(ctl));
    endtask

    task automatic idle_in();
        id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
        exe_dest = 5'd0; exe_mem_r_en = 1'b0; exe_wb_en = 1'b0;
        mem_dest = 5'd0; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; sram_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, release with idle inputs
        rst = 1'b1;
        idle_in();
        for (int i = 0; i < 4; i++) begin
            id_src1 = 5'($urandom); id_src2 = 5'($urandom); exe_dest = 5'($urandom);
            mem_dest = 5'($urandom);
            {id_two_src, exe_mem_r_en, exe_wb_en, mem_r_en, mem_w_en, mem_wb_en,
             branch_taken, sram_ready} = 8'($urandom);
            tick();
        end
        idle_in();
        tick();
        rst = 1'b0;
        #1;
        chk0("reset", 4'b1111, 3'b000);
        check_eq("reset.err", 32'(bus0.mem_err), 32'd0);
        check_eq("reset.cnt", bus0.stall_cycles, 32'd0);
        tick();
        chk0("reset.idle", 4'b1111, 3'b000);

        // Load-use on src1
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
        #1;
        chk0("lu.src1", 4'b0111, 3'b001);
        chk1("lu.src1", 4'b0111, 3'b001);
        tick();
        // Register 0 never stalls
        exe_dest = 5'd0; id_src1 = 5'd0;
        #1;
        chk0("lu.r0", 4'b1111, 3'b000);
        chk1("lu.r0", 4'b1111, 3'b000);
        tick();
        // Load-use on src2 only when it is read
        exe_dest = 5'd7; id_src1 = 5'd3; id_src2 = 5'd7; id_two_src = 1'b1;
        #1;
        chk0("lu.src2", 4'b0111, 3'b001);
        tick();
        id_two_src = 1'b0;
        #1;
        chk0("lu.nosrc2", 4'b1111, 3'b000);
        tick();
        check_eq("lu.cnt", bus0.stall_cycles, 32'd2);

        // Non-load writeback in EXE: stalls only without forwarding
        idle_in();
        exe_wb_en = 1'b1; exe_dest = 5'd9; id_src1 = 5'd9;
        #1;
        chk0("fwd.exe", 4'b1111, 3'b000);
        chk1("fwd.exe", 4'b0111, 3'b001);
        tick();
        // Writeback in MEM
        idle_in();
        mem_wb_en = 1'b1; mem_dest = 5'd4; id_src1 = 5'd4;
        #1;
        chk0("fwd.mem", 4'b1111, 3'b000);
        chk1("fwd.mem", 4'b0111, 3'b001);
        tick();
        mem_dest = 5'd0; id_src1 = 5'd0;
        #1;
        chk1("fwd.r0", 4'b1111, 3'b000);
        tick();
        check_eq("fwd.cnt0", bus0.stall_cycles, 32'd2);
        check_eq("fwd.cnt1", bus1.stall_cycles, 32'd4);

        // SRAM load, ready on 3rd WAIT cycle: frozen 4 cycles
        idle_in();
        mem_r_en = 1'b1;
        #1;
        chk0("sram.idle", 4'b0000, 3'b100);
        tick();
        chk0("sram.w0", 4'b0000, 3'b100);
        tick();
        chk0("sram.w1", 4'b0000, 3'b100);
        tick();
        sram_ready = 1'b1;
        #1;
        chk0("sram.w2", 4'b0000, 3'b100);
        tick();
        sram_ready = 1'b0;
        #1;
        chk0("sram.done", 4'b1111, 3'b000);
        idle_in();
        tick();
        chk0("sram.after", 4'b1111, 3'b000);
        check_eq("sram.cnt", bus0.stall_cycles, 32'd6);

        // Timeout: no ready, DONE after 4 WAIT cycles with sticky error
        mem_w_en = 1'b1;
        #1;
        chk0("to.idle", 4'b0000, 3'b100);
        tick();
        tick();
        tick();
        tick();
        chk0("to.w3", 4'b0000, 3'b100);
        check_eq("to.err_pre", 32'(bus0.mem_err), 32'd0);
        tick();
        chk0("to.done", 4'b1111, 3'b000);
        check_eq("to.err", 32'(bus0.mem_err), 32'd1);
        check_eq("to.err1", 32'(bus1.mem_err), 32'd1);
        idle_in();
        tick();
        exe_mem_r_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
        tick();
        idle_in();
        #1;
        check_eq("to.sticky", 32'(bus0.mem_err), 32'd1);
        check_eq("to.cnt", bus0.stall_cycles, 32'd12);

        // Branch during store stall is held until DONE
        branch_taken = 1'b1; mem_w_en = 1'b1;
        #1;
        chk0("br.idle", 4'b0000, 3'b100);
        tick();
        sram_ready = 1'b1;
        #1;
        chk0("br.w0", 4'b0000, 3'b100);
        tick();
        sram_ready = 1'b0;
        #1;
        chk0("br.done", 4'b1111, 3'b011);
        // Branch with simultaneous load-use: flush wins, no stall count
        mem_w_en = 1'b0;
        exe_mem_r_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
        tick();
        chk0("br.hz", 4'b1111, 3'b011);
        tick();
        idle_in();
        #1;
        check_eq("br.cnt", bus0.stall_cycles, 32'd14);
        check_eq("br.err", 32'(bus0.mem_err), 32'd1);

        // Async reset mid-WAIT drops sram_req before the next edge
        mem_r_en = 1'b1;
        tick();
        mem_r_en = 1'b0;
        #1;
        chk0("ar.wait", 4'b0000, 3'b100);
        #1;
        rst = 1'b1;
        #1;
        chk0("ar.rst", 4'b1111, 3'b000);
        check_eq("ar.err", 32'(bus0.mem_err), 32'd0);
        check_eq("ar.cnt", bus0.stall_cycles, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk0("ar.idle", 4'b1111, 3'b000);
        check_eq("ar.cnt2", bus0.stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
